// File: rtl/fpu_issue_ctrl.sv
// Issue controller for RV32F OP-FP instructions: decodes, sequences combinational
// and iterative-divide operations through the FPU, and drives the writeback port.
module fpu_issue_ctrl (
    input  logic        in_Clk,
    input  logic        in_Rst_N,
    input  logic        in_valid,
    output logic        out_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    input  logic        in_flush,
    output logic [4:0]  out_fpu_op,
    output logic [31:0] out_fpu_rs1,
    output logic [31:0] out_fpu_rs2,
    output logic        out_fpu_start,
    input  logic [31:0] in_fpu_data,
    input  logic        in_fpu_stall,
    output logic        out_wb_valid,
    output logic [4:0]  out_wb_rd,
    output logic [31:0] out_wb_data,
    output logic        out_wb_is_int,
    output logic        out_illegal
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_EXEC      = 3'd1,
        S_DIV_START = 3'd2,
        S_DIV_WAIT  = 3'd3,
        S_WB        = 3'd4
    } state_e;

    typedef struct packed {
        logic       legal;
        logic       is_div;
        logic       is_int;
        logic [4:0] op;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t       d;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [4:0] rs2;
        d   = '0;
        f7  = instr[31:25];
        f3  = instr[14:12];
        rs2 = instr[24:20];
        if (instr[6:0] == 7'h53) begin
            case (f7)
                7'b0000000: begin d.legal = 1'b1; d.op = 5'b00000; end
                7'b0000100: begin d.legal = 1'b1; d.op = 5'b00001; end
                7'b0001000: begin d.legal = 1'b1; d.op = 5'b00010; end
                7'b0001100: begin d.legal = 1'b1; d.op = 5'b00011; d.is_div = 1'b1; end
                7'b0101100: begin
                    if (rs2 == 5'd0) begin d.legal = 1'b1; d.op = 5'b00100; end
                    else begin d.legal = 1'b0; end
                end
                7'b0010000: begin
                    case (f3)
                        3'b000:  begin d.legal = 1'b1; d.op = 5'b00101; end
                        3'b001:  begin d.legal = 1'b1; d.op = 5'b00110; end
                        3'b010:  begin d.legal = 1'b1; d.op = 5'b00111; end
                        default: d.legal = 1'b0;
                    endcase
                end
                7'b0010100: begin
                    case (f3)
                        3'b000:  begin d.legal = 1'b1; d.op = 5'b10100; end
                        3'b001:  begin d.legal = 1'b1; d.op = 5'b10101; end
                        default: d.legal = 1'b0;
                    endcase
                end
                7'b1010000: begin
                    d.is_int = 1'b1;
                    case (f3)
                        3'b010:  begin d.legal = 1'b1; d.op = 5'b01000; end
                        3'b001:  begin d.legal = 1'b1; d.op = 5'b01001; end
                        3'b000:  begin d.legal = 1'b1; d.op = 5'b01010; end
                        default: d.legal = 1'b0;
                    endcase
                end
                7'b1100000: begin
                    d.is_int = 1'b1;
                    case (rs2)
                        5'd0:    begin d.legal = 1'b1; d.op = 5'b01100; end
                        5'd1:    begin d.legal = 1'b1; d.op = 5'b01101; end
                        default: d.legal = 1'b0;
                    endcase
                end
                7'b1101000: begin
                    case (rs2)
                        5'd0:    begin d.legal = 1'b1; d.op = 5'b01110; end
                        5'd1:    begin d.legal = 1'b1; d.op = 5'b01111; end
                        default: d.legal = 1'b0;
                    endcase
                end
                7'b1110000: begin
                    d.is_int = 1'b1;
                    if (rs2 == 5'd0 && f3 == 3'b000) begin d.legal = 1'b1; d.op = 5'b10000; end
                    else if (rs2 == 5'd0 && f3 == 3'b001) begin d.legal = 1'b1; d.op = 5'b10010; end
                    else begin d.legal = 1'b0; end
                end
                7'b1111000: begin
                    if (rs2 == 5'd0 && f3 == 3'b000) begin d.legal = 1'b1; d.op = 5'b10001; end
                    else begin d.legal = 1'b0; end
                end
                default: d = '0;
            endcase
        end else begin
            d = '0;
        end
        // An illegal word must not carry partial decode state into the pipeline.
        if (!d.legal) begin
            d = '0;
        end else begin
            d = d;
        end
        return d;
    endfunction

    state_e      state_q, state_d;
    logic        seen_busy_q, seen_busy_d;
    logic        wait_cnt_q, wait_cnt_d;
    logic [4:0]  op_q, op_d;
    logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        is_int_q, is_int_d;
    logic        illegal_q, illegal_d;
    logic        start_s;
    logic        accept_s;
    logic        div_done_s;
    dec_t        dec_s;
    logic        unused_rs1_field_s;

    assign unused_rs1_field_s = ^in_instr[19:15];
    assign dec_s      = decode(in_instr);
    assign out_ready  = (state_q == S_IDLE) & ~in_fpu_stall;
    assign accept_s   = in_valid & out_ready;
    // A divide that never raises stall within two wait cycles is treated as finished.
    assign div_done_s = ~in_fpu_stall & (seen_busy_q | wait_cnt_q);

    // Next-state, datapath latching and strobe generation.
    always_comb begin
        state_d     = state_q;
        seen_busy_d = seen_busy_q;
        wait_cnt_d  = wait_cnt_q;
        op_d        = op_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        is_int_d    = is_int_q;
        wb_data_d   = wb_data_q;
        wb_valid_d  = 1'b0;
        illegal_d   = 1'b0;
        start_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s && !in_flush) begin
                    op_d     = dec_s.op;
                    rs1_d    = in_rs1_val;
                    rs2_d    = in_rs2_val;
                    rd_d     = in_instr[11:7];
                    is_int_d = dec_s.is_int;
                    if (!dec_s.legal) begin
                        illegal_d = 1'b1;
                        state_d   = S_IDLE;
                    end else if (dec_s.is_div) begin
                        state_d = S_DIV_START;
                    end else begin
                        state_d = S_EXEC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                if (in_flush) begin
                    state_d = S_IDLE;
                end else begin
                    wb_data_d  = in_fpu_data;
                    wb_valid_d = 1'b1;
                    state_d    = S_WB;
                end
            end
            S_DIV_START: begin
                if (in_flush) begin
                    state_d = S_IDLE;
                end else begin
                    start_s     = 1'b1;
                    seen_busy_d = 1'b0;
                    wait_cnt_d  = 1'b0;
                    state_d     = S_DIV_WAIT;
                end
            end
            S_DIV_WAIT: begin
                if (in_flush) begin
                    state_d = S_IDLE;
                end else if (div_done_s) begin
                    wb_data_d  = in_fpu_data;
                    wb_valid_d = 1'b1;
                    state_d    = S_WB;
                end else begin
                    seen_busy_d = seen_busy_q | in_fpu_stall;
                    wait_cnt_d  = 1'b1;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge in_Clk) begin
        if (!in_Rst_N) begin
            state_q     <= S_IDLE;
            seen_busy_q <= 1'b0;
            wait_cnt_q  <= 1'b0;
            op_q        <= 5'd0;
            rs1_q       <= 32'd0;
            rs2_q       <= 32'd0;
            wb_valid_q  <= 1'b0;
            rd_q        <= 5'd0;
            wb_data_q   <= 32'd0;
            is_int_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            seen_busy_q <= seen_busy_d;
            wait_cnt_q  <= wait_cnt_d;
            op_q        <= op_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            wb_valid_q  <= wb_valid_d;
            rd_q        <= rd_d;
            wb_data_q   <= wb_data_d;
            is_int_q    <= is_int_d;
            illegal_q   <= illegal_d;
        end
    end

    // The start pulse is gated by flush in the same cycle, so it cannot be registered.
    assign out_fpu_start = start_s;
    assign out_fpu_op    = op_q;
    assign out_fpu_rs1   = rs1_q;
    assign out_fpu_rs2   = rs2_q;
    assign out_wb_valid  = wb_valid_q;
    assign out_wb_rd     = rd_q;
    assign out_wb_data   = wb_data_q;
    assign out_wb_is_int = is_int_q;
    assign out_illegal   = illegal_q;

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 in_Clk  input  1  single clock; all state changes on rising edge.
REQ-002 in_Rst_N  input  1  reset, synchronous, active-low.
REQ-003 in_valid  input  1  OP-FP instruction and operand values are presented.
REQ-004 out_ready  output  1  instruction accepted on a cycle with in_valid & out_ready.
REQ-005 in_instr  input  32  raw RV32F instruction word.
REQ-006 in_rs1_val / in_rs2_val  input  32 each  operand values, already read from the register file.
REQ-007 in_flush  input  1  discard the instruction in flight.
REQ-008 out_fpu_op  output  5  FPU opcode to the FPU datapath.
REQ-009 out_fpu_rs1 / out_fpu_rs2  output  32 each  FPU operands.
REQ-010 out_fpu_start  output  1  one-cycle start pulse to the iterative divider.
REQ-011 in_fpu_data  input  32  FPU result.
REQ-012 in_fpu_stall  input  1  FPU busy.
REQ-013 out_wb_valid  output  1  one-cycle writeback strobe.
REQ-014 out_wb_rd  output  5  destination register index.
REQ-015 out_wb_data  output  32  writeback value.
REQ-016 out_wb_is_int  output  1  1 = integer register file, 0 = FP register file.
REQ-017 out_illegal  output  1  one-cycle strobe for an undecodable instruction.

Function
REQ-018 FSM states: IDLE, EXEC, DIV_START, DIV_WAIT, WB; out_ready = (state==IDLE) & ~in_fpu_stall.
REQ-019 Accept at cycle T: latch rd=instr[11:7], operands, decoded op and is_int; choose next state.
- Divide: next state DIV_START.
- Illegal: next state IDLE.
- All other ops: next state EXEC.
REQ-020 Decode requires opcode 7'h53; funct7 selects the op; rm/funct3 ignored for add/sub/mul/div.
- 0000000 -> 00000; 0000100 -> 00001; 0001000 -> 00010; 0001100 -> 00011.
- 0101100 with rs2=0 -> 00100.
REQ-021 Decode continued (funct3 selects within a funct7 group):
- 0010000: funct3 000/001/010 -> 00101/00110/00111.
- 0010100: funct3 000/001 -> 10100/10101.
- 1010000: funct3 010/001/000 -> 01000/01001/01010, is_int=1.
REQ-022 Decode continued (rs2 field or funct3 selects):
- 1100000: rs2 0/1 -> 01100/01101, is_int=1.
- 1101000: rs2 0/1 -> 01110/01111.
- 1110000 with rs2=0: funct3 000 -> 10000; funct3 001 -> 10010; both is_int=1.
- 1111000 with funct3 000 and rs2=0 -> 10001.
- Any other encoding, including fused opcodes, is illegal.
REQ-023 Illegal instruction: out_illegal=1 at T+1; no start pulse, no out_wb_valid.
REQ-024 EXEC (T+1): drive latched op and operands, capture in_fpu_data into out_wb_data at end of cycle, go to WB.
REQ-025 WB: out_wb_valid=1 for exactly one cycle, then IDLE; combinational-op latency is accept-to-wb_valid = 2 cycles.
REQ-026 DIV_START: out_fpu_start=1 for exactly one cycle, then DIV_WAIT.
REQ-027 DIV_WAIT: set seen_busy when in_fpu_stall=1.
- Complete when seen_busy & ~in_fpu_stall, or when stall is not seen in the first 2 DIV_WAIT cycles.
- On completion, capture in_fpu_data and go to WB.
REQ-028 out_fpu_op, out_fpu_rs1 and out_fpu_rs2 are held stable from T+1 until WB is exited.
- In IDLE they retain their last values.
REQ-029 in_flush=1 in any state other than IDLE: next state IDLE; no out_wb_valid and no out_illegal for that instruction.
- A flush in DIV_START suppresses the start pulse.
REQ-030 in_flush coincident with accept: the instruction is dropped.
REQ-031 After a flush during a divide, out_ready stays 0 until in_fpu_stall=0.
REQ-032 out_wb_rd and out_wb_is_int are registered and remain valid while out_wb_valid=1.

Reset
REQ-033 in_Rst_N=0 at an edge:
- state returns to IDLE and seen_busy is cleared;
- all registered outputs go to 0: out_fpu_op, out_fpu_rs1/rs2, out_fpu_start, out_wb_valid, out_wb_rd, out_wb_data, out_wb_is_int, out_illegal;
- a reset mid-operation discards the instruction in flight.

Verification
REQ-034 FADD: instr 0x00208053, rs1=0x3F800000, rs2=0x40000000, FPU returns 0x40400000.
- Required: op=00000 at T+1; out_wb_valid at T+2 with rd=0, data=0x40400000, is_int=0.
REQ-035 FDIV: instr 0x18208053, in_fpu_stall high from T+2 to T+6.
- Required: exactly one start pulse, at T+1; op=00011 held throughout.
- Required: wb_valid one cycle after in_fpu_stall falls, with the captured data.
REQ-036 FEQ: instr 0xA020A2D3 with equal operands, FPU returns 0x1.
- Required: op=01000; wb_valid at T+2 with rd=5, data=0x00000001, is_int=1.
REQ-037 Illegal: instr 0xFE000053.
- Required: out_illegal=1 at T+1; no start pulse, no wb_valid; out_ready=1 at T+1.
REQ-038 Flush in DIV_WAIT while in_fpu_stall=1.
- Required: no wb_valid; out_ready=0 until stall falls, then 1.
REQ-039 Reset asserted in DIV_WAIT.
- Required: all outputs 0 next cycle and state IDLE; a following FADD completes normally.
